// File: rtl/ble_tx_scheduler.sv
// Round-robin scheduler for two 32-bit requesters sharing one BLE UART-TX command path:
// frames the granted word as "AT+BLEUARTTX=<8 hex>\r\n" and waits for an OK/ERROR reply.
module ble_tx_scheduler #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_W           = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        busy,
    output logic        grant_id,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP} state_t;

    localparam logic [4:0]      LAST_IDX = 5'd22;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          next_state;
    logic            last_grant;
    logic [31:0]     data_q;
    logic [4:0]      idx;
    logic [TO_W-1:0] to_cnt;
    logic            m_o;
    logic            pick1;
    logic            grant;
    logic            byte_accept;
    logic            success;
    logic            failure;
    logic [2:0]      hex_sel;
    logic [3:0]      nibble;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Requester 1 wins when it is alone or when a tie follows a requester-0 grant.
    always_comb begin
        next_state  = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        grant       = 1'b0;
        byte_accept = 1'b0;
        success     = 1'b0;
        failure     = 1'b0;
        pick1       = req1_valid && (!req0_valid || !last_grant);
        case (state)
            IDLE: begin
                if (!reset && (req0_valid || req1_valid)) begin
                    grant      = 1'b1;
                    req0_ready = !pick1;
                    req1_ready = pick1;
                    next_state = SEND;
                end
            end
            SEND: begin
                byte_accept = tx_ready;
                if (tx_ready && idx == LAST_IDX) begin
                    next_state = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                success = rx_valid && m_o && (rx_byte == 8'h4B);
                failure = !success &&
                          ((rx_valid && !m_o && (rx_byte == 8'h45)) || (to_cnt == TO_LAST));
                if (success || failure) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            data_q     <= 32'h0;
            idx        <= 5'd0;
            to_cnt     <= '0;
            m_o        <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done  <= success;
            error <= failure;
            if (grant) begin
                last_grant <= pick1;
                grant_id   <= pick1;
                data_q     <= pick1 ? req1_data : req0_data;
                idx        <= 5'd0;
            end
            if (byte_accept) begin
                idx <= idx + 5'd1;
                if (idx == LAST_IDX) begin
                    to_cnt <= '0;
                    m_o    <= 1'b0;
                end
            end
            // Matcher only remembers whether the previous byte was 'O'.
            if (state == WAIT_RESP) begin
                to_cnt <= to_cnt + TO_W'(1);
                if (rx_valid) begin
                    m_o <= (rx_byte == 8'h4F);
                end
            end
        end
    end

    always_comb begin
        hex_sel = 3'(idx - 5'd13);
        nibble  = 4'(data_q >> (5'd28 - {hex_sel, 2'b00}));
        tx_byte = 8'h00;
        if (state == SEND) begin
            case (idx)
                5'd0:    tx_byte = 8'h41;
                5'd1:    tx_byte = 8'h54;
                5'd2:    tx_byte = 8'h2B;
                5'd3:    tx_byte = 8'h42;
                5'd4:    tx_byte = 8'h4C;
                5'd5:    tx_byte = 8'h45;
                5'd6:    tx_byte = 8'h55;
                5'd7:    tx_byte = 8'h41;
                5'd8:    tx_byte = 8'h52;
                5'd9:    tx_byte = 8'h54;
                5'd10:   tx_byte = 8'h54;
                5'd11:   tx_byte = 8'h58;
                5'd12:   tx_byte = 8'h3D;
                5'd21:   tx_byte = 8'h0D;
                5'd22:   tx_byte = 8'h0A;
                default: tx_byte = (nibble < 4'd10) ? {4'h3, nibble} : (8'h37 + {4'h0, nibble});
            endcase
        end
    end

    assign tx_valid = (state == SEND);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ble_tx_scheduler.sv
// Bench for ble_tx_scheduler: randomized directed steps checked against a frame/arbiter
// model built from string and arithmetic rules; timeout shortened to 50 cycles.
module tb_ble_tx_scheduler;

    localparam int TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        busy;
    logic        grant_id;
    logic        done;
    logic        error;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        model_last = 1'b1;
    logic [7:0]  exp_frame[$];

    always #5 clk = ~clk;

    ble_tx_scheduler #(.TIMEOUT_CYCLES(TIMEOUT), .TO_W(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .busy       (busy),
        .grant_id   (grant_id),
        .done       (done),
        .error      (error)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkOutput(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic checkByte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkOutput(tag, {24'b0, obs}, {24'b0, exp});
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] d0,
                                 input logic v1, input logic [31:0] d1);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
    endtask

    // Expected frame: command text, eight uppercase hex digits MSB first, CR LF.
    task automatic build_frame(input logic [31:0] word);
        string prefix;
        int    nib;
        prefix = "AT+BLEUARTTX=";
        exp_frame.delete();
        for (int i = 0; i < prefix.len(); i++) exp_frame.push_back(prefix[i]);
        for (int i = 7; i >= 0; i--) begin
            nib = int'((word >> (4 * i)) & 32'hF);
            exp_frame.push_back((nib < 10) ? 8'(48 + nib) : 8'(55 + nib));
        end
        exp_frame.push_back(8'h0D);
        exp_frame.push_back(8'h0A);
    endtask

    // Called at a settled point with requests already driven; returns in the first response cycle.
    task automatic do_frame(input bit stall, input bit hold);
        logic        exp_gnt;
        logic [31:0] exp_word;
        int          idx;
        int          k;
        for (k = 0; k < 20 && !(req0_ready || req1_ready); k++) begin
            next_cycle();
            settle();
        end
        checkBit("grant_seen", req0_ready | req1_ready, 1'b1);
        exp_gnt    = (req0_valid && req1_valid) ? ~model_last : req1_valid;
        exp_word   = exp_gnt ? req1_data : req0_data;
        model_last = exp_gnt;
        checkBit("req0_ready", req0_ready, ~exp_gnt);
        checkBit("req1_ready", req1_ready, exp_gnt);
        checkBit("busy_idle", busy, 1'b0);
        build_frame(exp_word);
        next_cycle();
        if (!hold) applyStimulus(1'b0, $urandom, 1'b0, $urandom);
        settle();
        checkBit("grant_id", grant_id, exp_gnt);
        checkBit("busy_send", busy, 1'b1);
        checkBit("ready_low_send", req0_ready | req1_ready, 1'b0);
        idx = 0;
        for (k = 0; k < 400 && idx < 23; k++) begin
            tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rx_valid = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            rx_byte  = ($urandom_range(0, 1) == 0) ? 8'h4F : 8'h4B;
            settle();
            checkBit("tx_valid", tx_valid, 1'b1);
            checkByte($sformatf("tx_byte[%0d]", idx), tx_byte, exp_frame[idx]);
            checkBit("no_resp_send", done | error, 1'b0);
            if (tx_ready) idx++;
            next_cycle();
            settle();
        end
        rx_valid = 1'b0;
        tx_ready = 1'($urandom_range(0, 1));
        checkOutput("frame_bytes", 32'(idx), 32'd23);
        checkBit("tx_valid_drop", tx_valid, 1'b0);
        checkBit("busy_wait", busy, 1'b1);
    endtask

    // One rx byte per cycle; the reply pulse lands the cycle after the deciding byte.
    task automatic respond(input string s, input bit exp_ok, input int decide);
        for (int k = 0; k <= s.len(); k++) begin
            if (k > 0) next_cycle();
            rx_valid = (k < s.len());
            rx_byte  = (k < s.len()) ? s[k] : 8'h00;
            settle();
            checkBit("done", done, exp_ok && (k == decide + 1));
            checkBit("error", error, !exp_ok && (k == decide + 1));
            checkBit("busy_resp", busy, k <= decide);
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] word;

        reset    = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) next_cycle();
        req0_valid = 1'b1;
        settle();
        checkBit("rst_tx_valid", tx_valid, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_grant_id", grant_id, 1'b0);
        checkBit("rst_done", done, 1'b0);
        checkBit("rst_error", error, 1'b0);
        checkBit("rst_req0_ready", req0_ready, 1'b0);
        checkByte("rst_tx_byte", tx_byte, 8'h00);
        next_cycle();
        reset = 1'b0;
        req0_valid = 1'b0;

        $display("[TB] basic frame");
        next_cycle();
        applyStimulus(1'b1, 32'h1234ABCD, 1'b0, 32'h0);
        settle();
        do_frame(1'b0, 1'b0);
        respond("OK", 1'b1, 1);
        checkBit("basic_grant_id", grant_id, 1'b0);

        $display("[TB] timeout");
        next_cycle();
        applyStimulus(1'b1, $urandom, 1'b0, 32'h0);
        settle();
        do_frame(1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0BADF00D);
        settle();
        for (int k = 0; k <= TIMEOUT; k++) begin
            if (k > 0) begin
                next_cycle();
                settle();
            end
            checkBit("to_error", error, k == TIMEOUT);
            checkBit("to_done", done, 1'b0);
            checkBit("to_req1_ready", req1_ready, k == TIMEOUT);
        end
        do_frame(1'b0, 1'b0);
        respond("OK", 1'b1, 1);

        $display("[TB] fair arbitration");
        next_cycle();
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 32'h00000001);
        settle();
        for (int i = 0; i < 4; i++) begin
            do_frame(1'b0, i < 3);
            respond("OK", 1'b1, 1);
        end

        $display("[TB] error and noise");
        next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b1, $urandom);
        settle();
        do_frame(1'b0, 1'b0);
        respond("XO\r\nERROR\r\n", 1'b0, 4);
        next_cycle();
        applyStimulus(1'b1, $urandom, 1'b0, 32'h0);
        settle();
        do_frame(1'b0, 1'b0);
        respond("xOxOK", 1'b1, 4);

        $display("[TB] backpressure");
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'b1, $urandom);
            settle();
            do_frame(1'b1, 1'b0);
            respond("OK", 1'b1, 1);
        end

        $display("[TB] reset mid-frame");
        next_cycle();
        word = $urandom;
        build_frame(word);
        applyStimulus(1'b1, word, 1'b0, 32'h0);
        settle();
        checkBit("abort_req0_ready", req0_ready, 1'b1);
        next_cycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        tx_ready = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            checkByte("abort_pre_byte", tx_byte, exp_frame[k]);
            next_cycle();
            settle();
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        settle();
        checkBit("abort_tx_valid", tx_valid, 1'b0);
        checkBit("abort_busy", busy, 1'b0);
        model_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkBit("abort_no_resp", done | error, 1'b0);
            next_cycle();
            settle();
        end
        applyStimulus(1'b1, $urandom, 1'b1, $urandom);
        settle();
        do_frame(1'b0, 1'b0);
        respond("OK", 1'b1, 1);

        next_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
